// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_if
// Brief    : Request/response bundle between the fetch controller and pc_unit.
// Revision : 1.0  initial release
// ============================================================================
interface pc_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             Stall;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchOffset;
    logic             JumpEn;
    logic [WIDTH-1:0] JumpTarget;
    logic             JrEn;
    logic [WIDTH-1:0] JrTarget;
    logic             Call;
    logic             Ret;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCPlusStep;
    logic             Misaligned;
    logic [CNT_W-1:0] InstCount;
    logic             RasEmpty;
    logic             RasFull;

    modport master (
        output Stall, BranchTaken, BranchOffset, JumpEn, JumpTarget,
               JrEn, JrTarget, Call, Ret,
        input  PC, PCPlusStep, Misaligned, InstCount, RasEmpty, RasFull
    );

    modport slave (
        input  Stall, BranchTaken, BranchOffset, JumpEn, JumpTarget,
               JrEn, JrTarget, Call, Ret,
        output PC, PCPlusStep, Misaligned, InstCount, RasEmpty, RasFull
    );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program-counter stage with stall, retire counter and optional
//            return-address stack (enabled by defining PC_RAS_EN).
// Revision : 1.0  initial release
// ============================================================================
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               CNT_W     = 32,
    parameter int               RAS_DEPTH = 4
) (
    input  wire logic  Clk,
    input  wire logic  Reset_n,
    pc_unit_if.slave   bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             mis_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_jr_tgt;
    logic             w_ras_empty;
    logic             w_ras_full;

    assign w_pc_plus = pc_q + WIDTH'(STEP);
    assign w_br_tgt  = w_pc_plus + (bus.BranchOffset << 2);

    always_comb begin
        pc_d = w_pc_plus;
        if (bus.JrEn)             pc_d = w_jr_tgt;
        else if (bus.JumpEn)      pc_d = bus.JumpTarget;
        else if (bus.BranchTaken) pc_d = w_br_tgt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q  <= RESET_PC;
            mis_q <= |RESET_PC[1:0];
            cnt_q <= '0;
        end else if (!bus.Stall) begin
            pc_q  <= pc_d;
            mis_q <= |pc_d[1:0];
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    // sp_q is the next free slot; when full it also addresses the oldest entry,
    // so a push naturally overwrites the oldest return address.
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q;
    logic [PTR_W:0]   occ_q;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_pop;
    logic             w_push;

    assign w_ras_empty = (occ_q == '0);
    assign w_ras_full  = (occ_q == (PTR_W+1)'(RAS_DEPTH));
    assign w_top_idx   = sp_q - PTR_W'(1);
    assign w_pop       = bus.Ret & bus.JrEn & ~w_ras_empty;
    assign w_push      = bus.Call;
    assign w_jr_tgt    = w_pop ? ras_q[w_top_idx] : bus.JrTarget;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sp_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (!bus.Stall) begin
            if (w_push && w_pop) begin
                ras_q[w_top_idx] <= w_pc_plus;
            end else if (w_push) begin
                ras_q[sp_q] <= w_pc_plus;
                sp_q        <= sp_q + PTR_W'(1);
                if (!w_ras_full) occ_q <= occ_q + (PTR_W+1)'(1);
            end else if (w_pop) begin
                sp_q  <= w_top_idx;
                occ_q <= occ_q - (PTR_W+1)'(1);
            end
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic w_unused_ras;

    assign w_unused_ras = bus.Call ^ bus.Ret;
    assign w_jr_tgt     = bus.JrTarget;
    assign w_ras_empty  = 1'b1;
    assign w_ras_full   = 1'b0;
`endif

    assign bus.PC         = pc_q;
    assign bus.PCPlusStep = w_pc_plus;
    assign bus.Misaligned = mis_q;
    assign bus.InstCount  = cnt_q;
    assign bus.RasEmpty   = w_ras_empty;
    assign bus.RasFull    = w_ras_full;
endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Scoreboard bench for pc_unit with a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_unit;
    localparam int RDEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [31:0] cnt;
        logic        emp;
        logic        full;
    } exp_t;

    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_ras[$];

    pc_unit_if #(.WIDTH(32), .CNT_W(32)) bus ();

    pc_unit #(
        .WIDTH(32), .STEP(4), .RESET_PC(32'h0), .CNT_W(32), .RAS_DEPTH(RDEPTH)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pc   = m_pc;
        e.mis  = (m_pc[1:0] != 2'b00);
        e.cnt  = m_cnt;
        e.emp  = (m_ras.size() == 0);
        e.full = (m_ras.size() == RDEPTH);
        return e;
    endfunction

    // Architectural reference: next PC by priority, RAS as a bounded LIFO.
    task automatic model_step(input logic st, br, input logic [31:0] off,
                              input logic jmp, input logic [31:0] jt,
                              input logic jr, input logic [31:0] jrt,
                              input logic call, ret);
        logic [31:0] pcp, nxt;
        if (st) return;
        pcp = m_pc + 32'd4;
        if (jr)       nxt = jrt;
        else if (jmp) nxt = jt;
        else if (br)  nxt = pcp + off * 32'd4;
        else          nxt = pcp;
`ifdef PC_RAS_EN
        if (ret && jr && m_ras.size() > 0) nxt = m_ras.pop_back();
        if (call) begin
            m_ras.push_back(pcp);
            if (m_ras.size() > RDEPTH) void'(m_ras.pop_front());
        end
`endif
        m_pc  = nxt;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic cyc(input logic st, br, input logic [31:0] off,
                       input logic jmp, input logic [31:0] jt,
                       input logic jr, input logic [31:0] jrt,
                       input logic call, ret);
        @(negedge Clk);
        bus.Stall = st; bus.BranchTaken = br; bus.BranchOffset = off;
        bus.JumpEn = jmp; bus.JumpTarget = jt; bus.JrEn = jr; bus.JrTarget = jrt;
        bus.Call = call; bus.Ret = ret;
        model_step(st, br, off, jmp, jt, jr, jrt, call, ret);
        sb.push_back(snap());
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] t);
        cyc(0, 0, 0, 1, t, 0, 0, 0, 0);
    endtask

    task automatic quiet_stall();
        bus.Stall = 1; bus.BranchTaken = 0; bus.BranchOffset = 0; bus.JumpEn = 0;
        bus.JumpTarget = 0; bus.JrEn = 0; bus.JrTarget = 0; bus.Call = 0; bus.Ret = 0;
    endtask

    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", bus.PC, e.pc);
            chk("sb_pcplus", bus.PCPlusStep, e.pc + 32'd4);
            chk("sb_mis", {31'd0, bus.Misaligned}, {31'd0, e.mis});
            chk("sb_cnt", bus.InstCount, e.cnt);
            chk("sb_empty", {31'd0, bus.RasEmpty}, {31'd0, e.emp});
            chk("sb_full", {31'd0, bus.RasFull}, {31'd0, e.full});
        end
    end

    initial begin
        logic [31:0] saved_cnt;
        total = 0;
        bad   = 0;
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        quiet_stall();
        Reset_n = 1'b0;
        #3;
        chk("reset_pc", bus.PC, 32'h0);
        chk("reset_cnt", bus.InstCount, 32'h0);
        chk("reset_mis", {31'd0, bus.Misaligned}, 32'd0);
        chk("reset_empty", {31'd0, bus.RasEmpty}, 32'd1);
        chk("reset_full", {31'd0, bus.RasFull}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        idle(); idle(); idle();
        chk("seq_pc", bus.PC, 32'd12);
        chk("seq_cnt", bus.InstCount, 32'd3);

        jump(32'h100);
        cyc(0, 1, 32'h8, 1, 32'h500, 1, 32'h400, 0, 0);
        chk("prio_jr", bus.PC, 32'h400);
        jump(32'h100);
        cyc(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
        chk("branch_neg", bus.PC, 32'hFC);

        saved_cnt = bus.InstCount;
        cyc(1, 0, 0, 1, 32'h300, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h300, 0, 0, 0, 0);
        chk("stall_pc", bus.PC, 32'hFC);
        chk("stall_cnt", bus.InstCount, saved_cnt);
        jump(32'h200);
        chk("after_stall", bus.PC, 32'h200);

        jump(32'h202);
        chk("mis_pc", bus.PC, 32'h202);
        chk("mis_set", {31'd0, bus.Misaligned}, 32'd1);
        jump(32'h204);
        chk("mis_clr", {31'd0, bus.Misaligned}, 32'd0);

        jump(32'hFFFF_FFFC);
        idle();
        chk("pc_wrap", bus.PC, 32'h0);

`ifdef PC_RAS_EN
        jump(32'h10);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, 32'h10 * (i + 1), 0, 0, 1, 0);
        chk("ras_full", {31'd0, bus.RasFull}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 32'h998, 0, 1);
            chk("ras_pop", bus.PC, 32'h54 - 32'h10 * i);
        end
        chk("ras_empty", {31'd0, bus.RasEmpty}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 1);
        chk("ras_underflow", bus.PC, 32'h80);
`endif

        idle(); idle();
        @(negedge Clk);
        quiet_stall();
        Reset_n = 1'b0;
        #1;
        chk("async_pc", bus.PC, 32'h0);
        chk("async_cnt", bus.InstCount, 32'h0);
        chk("async_empty", {31'd0, bus.RasEmpty}, 32'd1);
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        m_ras.delete();
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            logic        st, br, jmp, jr, call, ret;
            logic [31:0] off, jt, jrt;
            st   = ($urandom % 5) == 0;
            br   = ($urandom % 4) == 0;
            jmp  = ($urandom % 8) == 0;
            ret  = ($urandom % 4) == 0;
            jr   = ret ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
            call = ($urandom % 4) == 0;
            off  = $urandom_range(0, 64) - 32;
            jt   = ($urandom % 6 == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            jrt  = $urandom & 32'h0000_FFFC;
            cyc(st, br, off, jmp, jt, jr, jrt, call, ret);
        end

        idle();
        @(posedge Clk);
        #2;
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
